// File: rtl/csr_commit_ctrl.sv
// csr_commit_ctrl: commit-stage CSR initiator. It commits exceptions, interrupts and ertn,
// flushes younger stages and redirects fetch. Optional macro CSR_REFETCH_EN makes CSR writes refetch.
module csr_commit_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [5:0]  ECODE_INT    = 6'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  output logic        ws_ready,
  input  logic [31:0] ws_pc,
  input  logic        ws_ex,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic [31:0] ws_vaddr,
  input  logic        ws_ertn,
  input  logic [1:0]  ws_csr_op,
  input  logic [13:0] ws_csr_num,
  input  logic [31:0] ws_csr_mask,
  input  logic [31:0] ws_csr_wdata,
  output logic        csr_re,
  output logic [13:0] csr_rnum,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [13:0] csr_wnum,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic [31:0] rf_csr_wdata,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        eret_flush,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  output logic        flush,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rpc_q, rpc_d;

  logic transfer;
  logic take_int;
  logic take_ex;
  logic ex_commit;
  logic take_ertn;
  logic csr_issue;
  logic take_refetch;
  logic event_fire;

  // resetn gates the handshake so no strobe can fire while reset is asserted
  assign transfer  = resetn & ws_valid & (state_q == RUN);
  assign take_int  = transfer & has_int;
  assign take_ex   = transfer & ~has_int & ws_ex;
  assign ex_commit = take_int | take_ex;
  assign take_ertn = transfer & ~ex_commit & ws_ertn;
  assign csr_issue = transfer & ~ex_commit;

  assign ws_ready = resetn & (state_q == RUN);

  assign csr_re       = csr_issue & (ws_csr_op != 2'b00);
  assign csr_we       = csr_issue & ws_csr_op[1];
  assign csr_rnum     = csr_re ? ws_csr_num : 14'd0;
  assign csr_wnum     = csr_we ? ws_csr_num : 14'd0;
  assign csr_wmask    = csr_we ? (ws_csr_op[0] ? ws_csr_mask : 32'hFFFF_FFFF) : 32'd0;
  assign csr_wvalue   = csr_we ? ws_csr_wdata : 32'd0;
  assign rf_csr_wdata = csr_rvalue;

`ifdef CSR_REFETCH_EN
  assign take_refetch = csr_we & ~take_ertn;
`else
  assign take_refetch = 1'b0;
`endif

  assign event_fire = ex_commit | take_ertn | take_refetch;

  assign wb_ex       = ex_commit;
  assign wb_ecode    = take_int ? ECODE_INT : (take_ex ? ws_ecode : 6'd0);
  assign wb_esubcode = take_ex ? ws_esubcode : 9'd0;
  assign wb_pc       = ex_commit ? ws_pc : 32'd0;
  assign wb_vaddr    = ex_commit ? ws_vaddr : 32'd0;
  assign eret_flush  = take_ertn;

  assign flush          = event_fire | (state_q == FLUSH);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = rpc_q;

  // Redirect target is captured once in the event cycle and held until the handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpc_d   = rpc_q;
    unique case (state_q)
      RUN: begin
        if (event_fire) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
          if (ex_commit)
            rpc_d = ex_entry;
          else if (take_ertn)
            rpc_d = ertn_entry;
          else
            rpc_d = ws_pc + 32'd4;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0)
          state_d = REDIRECT;
        else
          cnt_d = cnt_q - 4'd1;
      end
      REDIRECT: begin
        if (redirect_ready)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      rpc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpc_q   <= rpc_d;
    end
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// tb_csr_commit_ctrl: randomized and directed scenarios for csr_commit_ctrl against a
// priority-rule reference model; build with +define+CSR_REFETCH_EN to cover refetch.
module tb_csr_commit_ctrl;

  localparam int         FC   = 2;
  localparam logic [5:0] EINT = 6'h00;
`ifdef CSR_REFETCH_EN
  localparam bit REFETCH = 1'b1;
`else
  localparam bit REFETCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid, ws_ready;
  logic [31:0] ws_pc, ws_vaddr, ws_csr_mask, ws_csr_wdata;
  logic        ws_ex, ws_ertn;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic        csr_re, csr_we;
  logic [13:0] csr_rnum, csr_wnum;
  logic [31:0] csr_rvalue, csr_wmask, csr_wvalue, rf_csr_wdata;
  logic        wb_ex, eret_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        has_int;
  logic [31:0] ex_entry, ertn_entry;
  logic        flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  int vectors = 0;
  int miscompares = 0;

  csr_commit_ctrl #(.FLUSH_CYCLES(FC), .ECODE_INT(EINT)) dut (
    .clk(clk), .resetn(resetn),
    .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_pc(ws_pc), .ws_ex(ws_ex),
    .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode), .ws_vaddr(ws_vaddr), .ws_ertn(ws_ertn),
    .ws_csr_op(ws_csr_op), .ws_csr_num(ws_csr_num), .ws_csr_mask(ws_csr_mask),
    .ws_csr_wdata(ws_csr_wdata),
    .csr_re(csr_re), .csr_rnum(csr_rnum), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .rf_csr_wdata(rf_csr_wdata),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .eret_flush(eret_flush),
    .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    ws_valid = 0; ws_pc = 0; ws_ex = 0; ws_ecode = 0; ws_esubcode = 0; ws_vaddr = 0;
    ws_ertn = 0; ws_csr_op = 0; ws_csr_num = 0; ws_csr_mask = 0; ws_csr_wdata = 0;
    csr_rvalue = 0; has_int = 0; ex_entry = 0; ertn_entry = 0; redirect_ready = 0;
  endtask

  // Checks the flush window, the redirect stall and the handshake after an event cycle
  task automatic run_event_seq(input logic [31:0] target, input int stall,
                               input bit hold_ready, input bit int_during, input string tag);
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      ws_valid = 1; ws_ex = 1'($urandom); ws_ertn = 1'($urandom); ws_csr_op = 2'($urandom);
      has_int = int_during ? 1'b1 : 1'($urandom);
      ws_pc = $urandom; ex_entry = $urandom; ertn_entry = $urandom;
      redirect_ready = hold_ready;
      #1;
      vectors++;
      if (flush !== 1'b1 || ws_ready !== 1'b0 || redirect_valid !== 1'b0 || wb_ex !== 1'b0 ||
          eret_flush !== 1'b0 || csr_re !== 1'b0 || csr_we !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s flush_phase[%0d]: flush=%b ready=%b rv=%b wb_ex=%b eret=%b re=%b we=%b, required 1 0 0 0 0 0 0",
                 tag, i, flush, ws_ready, redirect_valid, wb_ex, eret_flush, csr_re, csr_we);
      end
      vectors++;
      if (redirect_pc !== target) begin
        miscompares++;
        $display("[TB] FAIL %s flush_phase_pc: got %h required %h", tag, redirect_pc, target);
      end
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      ws_valid = 1'($urandom); redirect_ready = 0;
      has_int = int_during ? 1'b1 : 1'($urandom);
      #1;
      vectors++;
      if (redirect_valid !== 1'b1 || flush !== 1'b0 || ws_ready !== 1'b0 || redirect_pc !== target ||
          wb_ex !== 1'b0 || csr_we !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s stall[%0d]: rv=%b flush=%b ready=%b pc=%h wb_ex=%b we=%b, required 1 0 0 %h 0 0",
                 tag, i, redirect_valid, flush, ws_ready, redirect_pc, wb_ex, csr_we, target);
      end
    end
    @(negedge clk);
    ws_valid = 0; redirect_ready = 1; has_int = int_during;
    #1;
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== target || flush !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s handshake: rv=%b pc=%h flush=%b, required 1 %h 0",
               tag, redirect_valid, redirect_pc, flush, target);
    end
  endtask

  task automatic check_idle_run(input string tag);
    @(negedge clk);
    clear_inputs();
    #1;
    vectors++;
    if (ws_ready !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0 || wb_ex !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s idle: ready=%b rv=%b flush=%b wb_ex=%b, required 1 0 0 0",
               tag, ws_ready, redirect_valid, flush, wb_ex);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 0;
    ws_valid = 1; ws_ex = 1; has_int = 1; ws_ertn = 1; ws_csr_op = 2'b11; redirect_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (wb_ex !== 1'b0 || eret_flush !== 1'b0 || csr_re !== 1'b0 || csr_we !== 1'b0 ||
        flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: wb_ex=%b eret=%b re=%b we=%b flush=%b rv=%b pc=%h, required all 0",
               wb_ex, eret_flush, csr_re, csr_we, flush, redirect_valid, redirect_pc);
    end
    @(negedge clk);
    clear_inputs();
    resetn = 1;
    check_idle_run("reset_release");
  endtask

  task automatic test_csr_xchg();
    @(negedge clk);
    clear_inputs();
    ws_valid = 1; ws_csr_op = 2'b11; ws_csr_num = 14'h4; ws_csr_mask = 32'h0000_0004;
    ws_csr_wdata = 32'hFFFF_FFFF; csr_rvalue = 32'h1234_5678; redirect_ready = 1; ws_pc = 32'h1C00_0200;
    #1;
    vectors++;
    if (csr_we !== 1'b1 || csr_re !== 1'b1 || csr_wmask !== 32'h4 || csr_wvalue !== 32'hFFFF_FFFF ||
        csr_wnum !== 14'h4 || csr_rnum !== 14'h4 || rf_csr_wdata !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL csrxchg: we=%b re=%b mask=%h val=%h wnum=%h rnum=%h rf=%h, required 1 1 4 ffffffff 4 4 12345678",
               csr_we, csr_re, csr_wmask, csr_wvalue, csr_wnum, csr_rnum, rf_csr_wdata);
    end
    vectors++;
    if (flush !== REFETCH || wb_ex !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL csrxchg_flush: flush=%b wb_ex=%b, required %b 0", flush, wb_ex, REFETCH);
    end
`ifdef CSR_REFETCH_EN
    run_event_seq(32'h1C00_0204, 0, 1, 0, "csrxchg_refetch");
`endif
    check_idle_run("csrxchg");
  endtask

  task automatic test_exception();
    @(negedge clk);
    clear_inputs();
    ws_valid = 1; ws_ex = 1; ws_ecode = 6'h08; ws_esubcode = 9'h003; ws_pc = 32'h1C00_0100;
    ws_vaddr = 32'hBEEF_0010; ex_entry = 32'h1C00_8000; ws_csr_op = 2'b10;
    #1;
    vectors++;
    if (wb_ex !== 1'b1 || wb_pc !== 32'h1C00_0100 || wb_ecode !== 6'h08 || wb_esubcode !== 9'h003 ||
        wb_vaddr !== 32'hBEEF_0010 || flush !== 1'b1 || csr_we !== 1'b0 || eret_flush !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL exception: wb_ex=%b pc=%h ecode=%h sub=%h vaddr=%h flush=%b we=%b eret=%b, required 1 1c000100 08 003 beef0010 1 0 0",
               wb_ex, wb_pc, wb_ecode, wb_esubcode, wb_vaddr, flush, csr_we, eret_flush);
    end
    run_event_seq(32'h1C00_8000, 2, 0, 0, "exception");
    check_idle_run("exception");
  endtask

  task automatic test_int_priority();
    @(negedge clk);
    clear_inputs();
    ws_valid = 1; has_int = 1; ws_ex = 1; ws_ecode = 6'h0B; ws_esubcode = 9'h005;
    ws_ertn = 1; ws_pc = 32'h1C00_0300; ex_entry = 32'h1C00_9000;
    #1;
    vectors++;
    if (wb_ex !== 1'b1 || wb_ecode !== EINT || wb_esubcode !== 9'd0 || eret_flush !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL int_priority: wb_ex=%b ecode=%h sub=%h eret=%b, required 1 %h 000 0",
               wb_ex, wb_ecode, wb_esubcode, eret_flush, EINT);
    end
    run_event_seq(32'h1C00_9000, 0, 1, 0, "int_priority");
    check_idle_run("int_priority");
  endtask

  task automatic test_ertn();
    @(negedge clk);
    clear_inputs();
    ws_valid = 1; ws_ertn = 1; ertn_entry = 32'h1C00_0104; ex_entry = 32'h1C00_8000;
    #1;
    vectors++;
    if (eret_flush !== 1'b1 || wb_ex !== 1'b0 || flush !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ertn: eret=%b wb_ex=%b flush=%b, required 1 0 1", eret_flush, wb_ex, flush);
    end
    run_event_seq(32'h1C00_0104, 1, 0, 0, "ertn");
    check_idle_run("ertn");
  endtask

  task automatic test_idle_int();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      has_int = 1; ws_ex = 1; ws_csr_op = 2'b10;
      #1;
      vectors++;
      if (wb_ex !== 1'b0 || flush !== 1'b0 || csr_re !== 1'b0 || csr_we !== 1'b0 || ws_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL idle_int[%0d]: wb_ex=%b flush=%b re=%b we=%b ready=%b, required 0 0 0 0 1",
                 i, wb_ex, flush, csr_re, csr_we, ws_ready);
      end
    end
  endtask

  task automatic test_int_after_flush();
    @(negedge clk);
    clear_inputs();
    ws_valid = 1; ws_ex = 1; ws_ecode = 6'h01; ex_entry = 32'h0000_4000;
    #1;
    run_event_seq(32'h0000_4000, 1, 0, 1, "int_during_flush");
    @(negedge clk);
    clear_inputs();
    ws_valid = 1; has_int = 1; ws_pc = 32'h0000_1230; ex_entry = 32'h0000_5000;
    #1;
    vectors++;
    if (ws_ready !== 1'b1 || wb_ex !== 1'b1 || wb_ecode !== EINT || wb_pc !== 32'h0000_1230) begin
      miscompares++;
      $display("[TB] FAIL int_after_flush: ready=%b wb_ex=%b ecode=%h pc=%h, required 1 1 %h 00001230",
               ws_ready, wb_ex, wb_ecode, wb_pc, EINT);
    end
    run_event_seq(32'h0000_5000, 0, 0, 0, "int_after_flush");
    check_idle_run("int_after_flush");
  endtask

  task automatic test_stall_reset();
    @(negedge clk);
    clear_inputs();
    ws_valid = 1; ws_ex = 1; ex_entry = 32'h1C00_A000;
    repeat (FC) begin
      @(negedge clk);
      clear_inputs();
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ws_valid = 1;
      #1;
      vectors++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_A000 || ws_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold[%0d]: rv=%b pc=%h ready=%b, required 1 1c00a000 0",
                 i, redirect_valid, redirect_pc, ws_ready);
      end
    end
    @(negedge clk);
    resetn = 0; ws_valid = 1; ws_ex = 1; ws_csr_op = 2'b11;
    #1;
    vectors++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || flush !== 1'b0 || wb_ex !== 1'b0 ||
        csr_we !== 1'b0 || csr_re !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_reset: rv=%b pc=%h flush=%b wb_ex=%b we=%b re=%b, required all 0",
               redirect_valid, redirect_pc, flush, wb_ex, csr_we, csr_re);
    end
    @(negedge clk);
    clear_inputs();
    resetn = 1;
    check_idle_run("stall_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] tgt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      clear_inputs();
      tgt = $urandom;
      ws_valid = 1; ws_ex = 1; ws_ecode = 6'(k + 2); ws_pc = $urandom; ex_entry = tgt;
      #1;
      vectors++;
      if (ws_ready !== 1'b1 || wb_ex !== 1'b1 || wb_ecode !== 6'(k + 2)) begin
        miscompares++;
        $display("[TB] FAIL back_to_back[%0d]: ready=%b wb_ex=%b ecode=%h, required 1 1 %h",
                 k, ws_ready, wb_ex, wb_ecode, 6'(k + 2));
      end
      run_event_seq(tgt, 0, 1, 0, "back_to_back");
    end
    check_idle_run("back_to_back");
  endtask

`ifdef CSR_REFETCH_EN
  task automatic test_refetch();
    @(negedge clk);
    clear_inputs();
    ws_valid = 1; ws_csr_op = 2'b10; ws_pc = 32'hFFFF_FFFC; ws_csr_num = 14'h10; ws_csr_wdata = $urandom;
    #1;
    vectors++;
    if (csr_we !== 1'b1 || csr_wmask !== 32'hFFFF_FFFF || flush !== 1'b1 || wb_ex !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL refetch: we=%b mask=%h flush=%b wb_ex=%b, required 1 ffffffff 1 0",
               csr_we, csr_wmask, flush, wb_ex);
    end
    run_event_seq(32'h0000_0000, 1, 0, 0, "refetch_wrap");
    check_idle_run("refetch");
  endtask
`endif

  // Reference: priority interrupt > exception > ertn > refetch; CSR ops only without ex/int
  task automatic test_random(input int n);
    bit exp_int, exp_ex, exp_ertn, exp_re, exp_we, exp_evt;
    logic [31:0] exp_tgt, exp_mask;
    logic [5:0]  exp_ecode;
    logic [8:0]  exp_sub;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      clear_inputs();
      ws_valid = ($urandom_range(0, 4) != 0);
      has_int = ($urandom_range(0, 5) == 0);
      ws_ex = ($urandom_range(0, 3) == 0);
      ws_ertn = ($urandom_range(0, 4) == 0);
      ws_csr_op = 2'($urandom); ws_csr_num = 14'($urandom);
      ws_csr_mask = $urandom; ws_csr_wdata = $urandom; csr_rvalue = $urandom;
      ws_ecode = 6'($urandom); ws_esubcode = 9'($urandom);
      ws_pc = $urandom; ws_vaddr = $urandom; ex_entry = $urandom; ertn_entry = $urandom;
      exp_int  = ws_valid && has_int;
      exp_ex   = ws_valid && !has_int && ws_ex;
      exp_ertn = ws_valid && !exp_int && !exp_ex && ws_ertn;
      exp_re   = ws_valid && !exp_int && !exp_ex && (ws_csr_op != 0);
      exp_we   = ws_valid && !exp_int && !exp_ex && (ws_csr_op >= 2);
      exp_evt  = exp_int || exp_ex || exp_ertn || (REFETCH && exp_we);
      exp_tgt  = (exp_int || exp_ex) ? ex_entry : (exp_ertn ? ertn_entry : ws_pc + 32'd4);
      exp_mask = (ws_csr_op == 3) ? ws_csr_mask : 32'hFFFF_FFFF;
      exp_ecode = exp_int ? EINT : ws_ecode;
      exp_sub   = exp_int ? 9'd0 : ws_esubcode;
      #1;
      vectors++;
      if (wb_ex !== (exp_int || exp_ex) || eret_flush !== exp_ertn || csr_re !== exp_re ||
          csr_we !== exp_we || flush !== exp_evt || ws_ready !== 1'b1 || rf_csr_wdata !== csr_rvalue) begin
        miscompares++;
        $display("[TB] FAIL rand[%0d] strobes: wb_ex=%b eret=%b re=%b we=%b flush=%b ready=%b rf=%h, required %b %b %b %b %b 1 %h",
                 k, wb_ex, eret_flush, csr_re, csr_we, flush, ws_ready, rf_csr_wdata,
                 exp_int || exp_ex, exp_ertn, exp_re, exp_we, exp_evt, csr_rvalue);
      end
      if (exp_int || exp_ex) begin
        vectors++;
        if (wb_ecode !== exp_ecode || wb_esubcode !== exp_sub || wb_pc !== ws_pc || wb_vaddr !== ws_vaddr) begin
          miscompares++;
          $display("[TB] FAIL rand[%0d] ex_info: ecode=%h sub=%h pc=%h vaddr=%h, required %h %h %h %h",
                   k, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, exp_ecode, exp_sub, ws_pc, ws_vaddr);
        end
      end
      if (exp_we) begin
        vectors++;
        if (csr_wmask !== exp_mask || csr_wvalue !== ws_csr_wdata || csr_wnum !== ws_csr_num) begin
          miscompares++;
          $display("[TB] FAIL rand[%0d] csr_write: mask=%h val=%h num=%h, required %h %h %h",
                   k, csr_wmask, csr_wvalue, csr_wnum, exp_mask, ws_csr_wdata, ws_csr_num);
        end
      end
      if (exp_re) begin
        vectors++;
        if (csr_rnum !== ws_csr_num) begin
          miscompares++;
          $display("[TB] FAIL rand[%0d] csr_rnum: got %h required %h", k, csr_rnum, ws_csr_num);
        end
      end
      if (exp_evt)
        run_event_seq(exp_tgt, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, "rand_event");
    end
    check_idle_run("random");
  endtask

  initial begin
    test_reset();
    test_csr_xchg();
    test_exception();
    test_int_priority();
    test_ertn();
    test_idle_int();
    test_int_after_flush();
    test_stall_reset();
    test_back_to_back();
`ifdef CSR_REFETCH_EN
    test_refetch();
`endif
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
